conv3x3_mode_filter: RTL and testbench
======================================

CONV3X3_MODE_FILTER -- requirements
Module: conv3x3_mode_filter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning unsigned pixel width (range 4..16).
REQ-002 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cfg_mode  input  2  kernel select: 0 bypass, 1 smooth, 2 sharpen, 3 edge.
REQ-005 SHALL have port act_mode  output  2  mode applied to the current frame.
REQ-006 SHALL have ports in3x3_val input 1, in3x3_rdy output 1: valid/ready of the input window beat.
REQ-007 SHALL have port in3x3_data  input  9*DATA_WIDTH  window; p00 at MSBs, row-major, p22 at LSBs.
REQ-008 SHALL have ports in3x3_sof, in3x3_sol, in3x3_eol, in3x3_eof  input  1 each  frame markers, qualified by in3x3_val.
REQ-009 SHALL have ports out_val output 1, out_rdy input 1, out_data output DATA_WIDTH: result stream.
REQ-010 SHALL have ports out_sof, out_sol, out_eol, out_eof  output  1 each  markers aligned with out_data.

Function
REQ-011 SHALL use the following kernels: smooth [1 2 1;2 4 2;1 2 1] then arithmetic shift right 4; sharpen [0 -1 0;-1 5 -1;0 -1 0]; edge [-1 -1 -1;-1 8 -1;-1 -1 -1]; bypass outputs p11.
REQ-012 SHALL use only shift and add arithmetic in a signed accumulator of DATA_WIDTH+5 bits, with no overflow for any input.
REQ-013 SHALL clamp results: greater than 2^DATA_WIDTH-1 gives all-ones; negative gives 0 (see REQ-026).
REQ-014 SHALL implement a 2-stage pipeline: S1 registers the three row partial sums and markers, S2 registers the final sum, shift, saturate and markers; latency is exactly 2 cycles from an accepted beat with out_rdy held high.
REQ-015 SHALL define en2 = out_rdy | ~out_val, en1 = en2 | ~s1_val, and in3x3_rdy = en1.
REQ-016 SHALL accept a beat only on in3x3_val & in3x3_rdy; with out_rdy low, S1 and S2 fill, then in3x3_rdy goes low; no beat is lost or duplicated.
REQ-017 SHALL hold out_data, out_val and all markers stable while out_val & ~out_rdy.
REQ-018 SHALL carry markers with their own beat through both stages, never as independent sticky flags.
REQ-019 SHALL sample cfg_mode into the mode register on each accepted beat with in3x3_sof=1 and apply it from that beat through the end of the frame; cfg_mode changes mid-frame are ignored.
REQ-020 SHALL process beats accepted before any SOF in the reset mode (bypass).
REQ-021 SHALL carry the mode tag with each beat through S1, so the beat in flight is not affected by a new SOF.
REQ-022 SHALL drive act_mode equal to the mode register.
REQ-023 SHALL treat a beat with sof and eof both set (1-pixel frame) as normal.

Reset
REQ-024 SHALL clear all registers asynchronously on rst_n low: out_val, out_data, all out markers, S1/S2 valids = 0; act_mode = 0.
REQ-025 SHALL discard in-flight beats on reset mid-frame; the first output after reset belongs to a beat accepted after release.

Configuration
REQ-026 SHALL use macro CONV3X3_ABS_EN: when defined, modes 2 and 3 output |sum| saturated to all-ones; when undefined, negative sums clamp to 0; modes 0 and 1 are unaffected either way.

Verification
REQ-027 SHALL cover smooth, W=8: all nine pixels 255 -> out_data 255; window p11=16, others 0 -> out_data 4, two cycles after acceptance.
REQ-028 SHALL cover edge: p11=0, others 10 -> out 0 without macro, 80 with CONV3X3_ABS_EN; p11=200, others 0 -> 255.
REQ-029 SHALL cover mode latch: cfg_mode=1 at SOF, switched to 2 mid-frame -> act_mode stays 1 until the next SOF beat, then becomes 2.
REQ-030 SHALL cover backpressure: a stream of 10 beats with out_rdy toggling pseudo-randomly -> 10 outputs in order, markers on the correct beats, in3x3_rdy low only when S1 and S2 are full.
REQ-031 SHALL cover reset: rst_n pulsed with 2 beats in flight -> out_val=0 immediately, act_mode=0, no stale output afterwards.

Source files
------------

// File: rtl/conv3x3_mode_filter.sv
// rtl/conv3x3_mode_filter.sv - 3x3 window filter (bypass/smooth/sharpen/edge), 2-stage valid/ready pipeline.
// Optional CONV3X3_ABS_EN: sharpen/edge output |sum| instead of clamping negatives to zero.
module conv3x3_mode_filter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              cfg_mode,
  output logic [1:0]              act_mode,
  input  logic                    in3x3_val,
  output logic                    in3x3_rdy,
  input  logic [9*DATA_WIDTH-1:0] in3x3_data,
  input  logic                    in3x3_sof,
  input  logic                    in3x3_sol,
  input  logic                    in3x3_eol,
  input  logic                    in3x3_eof,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_sof,
  output logic                    out_sol,
  output logic                    out_eol,
  output logic                    out_eof
);

  localparam int AW = DATA_WIDTH + 5;
  localparam logic signed [AW-1:0] C_MAX = AW'((1 << DATA_WIDTH) - 1);

  logic                   w_en1;
  logic                   w_en2;
  logic                   w_acc;
  logic [1:0]             w_mode;
  logic signed [AW-1:0]   w_px [9];
  logic signed [AW-1:0]   w_row [3];
  logic signed [AW-1:0]   w_sum;
  logic signed [AW-1:0]   w_shf;
  logic signed [AW-1:0]   w_mag;
  logic [DATA_WIDTH-1:0]  w_res;

  logic [1:0]             r_mode;
  logic                   r_s1_val;
  logic signed [AW-1:0]   r_s1_row [3];
  logic [1:0]             r_s1_mode;
  logic [3:0]             r_s1_mk;
  logic                   r_out_val;
  logic [DATA_WIDTH-1:0]  r_out_data;
  logic [3:0]             r_out_mk;

  assign w_en2     = out_rdy | ~r_out_val;
  assign w_en1     = w_en2 | ~r_s1_val;
  assign in3x3_rdy = w_en1;
  assign w_acc     = in3x3_val & w_en1;
  // An SOF beat already uses the mode it brings; the register only follows.
  assign w_mode    = in3x3_sof ? cfg_mode : r_mode;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_px
      assign w_px[gi] = $signed({5'b0, in3x3_data[(8-gi)*DATA_WIDTH +: DATA_WIDTH]});
    end
  endgenerate

  always_comb begin
    w_row[0] = '0;
    w_row[1] = '0;
    w_row[2] = '0;
    case (w_mode)
      2'd1: begin
        w_row[0] = w_px[0] + (w_px[1] <<< 1) + w_px[2];
        w_row[1] = (w_px[3] <<< 1) + (w_px[4] <<< 2) + (w_px[5] <<< 1);
        w_row[2] = w_px[6] + (w_px[7] <<< 1) + w_px[8];
      end
      2'd2: begin
        w_row[0] = -w_px[1];
        w_row[1] = (w_px[4] <<< 2) + w_px[4] - w_px[3] - w_px[5];
        w_row[2] = -w_px[7];
      end
      2'd3: begin
        w_row[0] = -(w_px[0] + w_px[1] + w_px[2]);
        w_row[1] = (w_px[4] <<< 3) - w_px[3] - w_px[5];
        w_row[2] = -(w_px[6] + w_px[7] + w_px[8]);
      end
      default: w_row[1] = w_px[4];
    endcase
  end

  always_comb begin
    w_sum = r_s1_row[0] + r_s1_row[1] + r_s1_row[2];
    w_shf = (r_s1_mode == 2'd1) ? (w_sum >>> 4) : w_sum;
    w_mag = w_shf;
`ifdef CONV3X3_ABS_EN
    if (r_s1_mode[1] && w_shf[AW-1]) begin
      w_mag = -w_shf;
    end
`endif
    if (w_mag[AW-1]) begin
      w_res = '0;
    end else if (w_mag > C_MAX) begin
      w_res = '1;
    end else begin
      w_res = w_mag[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= '0;
      r_s1_val    <= 1'b0;
      r_s1_row[0] <= '0;
      r_s1_row[1] <= '0;
      r_s1_row[2] <= '0;
      r_s1_mode   <= '0;
      r_s1_mk     <= '0;
      r_out_val   <= 1'b0;
      r_out_data  <= '0;
      r_out_mk    <= '0;
    end else begin
      if (w_acc && in3x3_sof) begin
        r_mode <= cfg_mode;
      end
      if (w_en1) begin
        r_s1_val <= in3x3_val;
        if (in3x3_val) begin
          r_s1_row[0] <= w_row[0];
          r_s1_row[1] <= w_row[1];
          r_s1_row[2] <= w_row[2];
          r_s1_mode   <= w_mode;
          r_s1_mk     <= {in3x3_sof, in3x3_sol, in3x3_eol, in3x3_eof};
        end
      end
      if (w_en2) begin
        r_out_val <= r_s1_val;
        r_out_mk  <= r_s1_val ? r_s1_mk : 4'b0000;
        if (r_s1_val) begin
          r_out_data <= w_res;
        end
      end
    end
  end

  assign act_mode = r_mode;
  assign out_val  = r_out_val;
  assign out_data = r_out_data;
  assign out_sof  = r_out_mk[3];
  assign out_sol  = r_out_mk[2];
  assign out_eol  = r_out_mk[1];
  assign out_eof  = r_out_mk[0];

endmodule

// File: tb/tb_conv3x3_mode_filter.sv
// tb/tb_conv3x3_mode_filter.sv - vector table, hand sequences and randomized stream against a kernel reference model.
module tb_conv3x3_mode_filter;

  localparam int W = 8;
`ifdef CONV3X3_ABS_EN
  localparam bit ABS = 1'b1;
`else
  localparam bit ABS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     cfg_mode = '0;
  logic [1:0]     act_mode;
  logic           in3x3_val = 1'b0;
  logic           in3x3_rdy;
  logic [9*W-1:0] in3x3_data = '0;
  logic           in3x3_sof = 1'b0, in3x3_sol = 1'b0, in3x3_eol = 1'b0, in3x3_eof = 1'b0;
  logic           out_val;
  logic           out_rdy = 1'b0;
  logic [W-1:0]   out_data;
  logic           out_sof, out_sol, out_eol, out_eof;

  conv3x3_mode_filter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .act_mode(act_mode),
    .in3x3_val(in3x3_val), .in3x3_rdy(in3x3_rdy), .in3x3_data(in3x3_data),
    .in3x3_sof(in3x3_sof), .in3x3_sol(in3x3_sol), .in3x3_eol(in3x3_eol), .in3x3_eof(in3x3_eof),
    .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
    .out_sof(out_sof), .out_sol(out_sol), .out_eol(out_eol), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic [3:0] mk; } exp_t;
  typedef struct { logic [1:0] mode; logic [71:0] win; int exp; } vec_t;

  exp_t       q[$];
  logic [1:0] m_mode = '0;
  int         n_pass = 0;
  int         n_tot = 0;
  logic       st_valid = 1'b0;
  logic [7:0] st_data;
  logic [3:0] st_mk;
  logic       acc, dlv;
  vec_t       tv[12];

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [71:0] win9(input logic [7:0] a, b, c, d, e, f, g, h, i);
    return {a, b, c, d, e, f, g, h, i};
  endfunction

  function automatic int ref_px(input logic [1:0] mode, input logic [71:0] win);
    int p[9];
    int k[9];
    int s;
    for (int i = 0; i < 9; i++) p[i] = int'(win[(8-i)*8 +: 8]);
    case (mode)
      2'd1:    k = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
      2'd2:    k = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
      2'd3:    k = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
      default: k = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    endcase
    s = 0;
    for (int i = 0; i < 9; i++) s += k[i] * p[i];
    if (mode == 2'd1) s = s / 16;
    if (ABS && s < 0) s = -s;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  // One clock: drive at negedge, sample 1ns later, advance the model for the coming posedge.
  task automatic cyc(input logic v, input logic [71:0] d, input logic [3:0] mk,
                     input logic [1:0] cfg, input logic ordy, output logic a, output logic dl);
    logic [1:0] bm;
    exp_t e;
    @(negedge clk);
    in3x3_val = v; in3x3_data = d; cfg_mode = cfg; out_rdy = ordy;
    {in3x3_sof, in3x3_sol, in3x3_eol, in3x3_eof} = mk;
    #1;
    if (st_valid) begin
      chk("hold_val", int'(out_val), 1);
      chk("hold_data", int'(out_data), int'(st_data));
      chk("hold_mk", int'({out_sof, out_sol, out_eol, out_eof}), int'(st_mk));
    end
    st_valid = out_val & ~ordy;
    st_data = out_data;
    st_mk = {out_sof, out_sol, out_eol, out_eof};
    chk("in_rdy", int'(in3x3_rdy), int'(!(q.size() == 2 && !ordy)));
    chk("act_mode", int'(act_mode), int'(m_mode));
    a = v & in3x3_rdy;
    dl = out_val & ordy;
    if (dl) begin
      if (q.size() == 0) begin
        chk("out_unexpected", int'(q.size()), 1);
      end else begin
        e = q.pop_front();
        chk("out_data", int'(out_data), int'(e.data));
        chk("out_mk", int'({out_sof, out_sol, out_eol, out_eof}), int'(e.mk));
      end
    end
    if (a) begin
      bm = mk[3] ? cfg : m_mode;
      e.data = 8'(ref_px(bm, d));
      e.mk = mk;
      q.push_back(e);
      if (mk[3]) m_mode = cfg;
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 4'b0000, 2'd0, ordy, acc, dlv);
  endtask

  initial begin
    logic [95:0] rnd;
    int beat, n_out, ncy, idx;
    logic v;

    tv[0]  = '{2'd1, win9(255, 255, 255, 255, 255, 255, 255, 255, 255), 255};
    tv[1]  = '{2'd1, win9(0, 0, 0, 0, 16, 0, 0, 0, 0), 4};
    tv[2]  = '{2'd3, win9(10, 10, 10, 10, 0, 10, 10, 10, 10), ABS ? 80 : 0};
    tv[3]  = '{2'd3, win9(0, 0, 0, 0, 200, 0, 0, 0, 0), 255};
    tv[4]  = '{2'd0, win9(200, 200, 200, 200, 77, 200, 200, 200, 200), 77};
    tv[5]  = '{2'd2, win9(10, 10, 10, 10, 50, 10, 10, 10, 10), 210};
    tv[6]  = '{2'd2, win9(0, 100, 0, 0, 0, 0, 0, 0, 0), ABS ? 100 : 0};
    tv[7]  = '{2'd2, win9(0, 0, 0, 0, 100, 0, 0, 0, 0), 255};
    tv[8]  = '{2'd1, win9(15, 0, 0, 0, 0, 0, 0, 0, 0), 0};
    tv[9]  = '{2'd3, win9(255, 255, 255, 255, 255, 255, 255, 255, 255), 0};
    tv[10] = '{2'd2, win9(255, 255, 255, 255, 255, 255, 255, 255, 255), 255};
    tv[11] = '{2'd3, win9(255, 255, 255, 255, 0, 255, 255, 255, 255), ABS ? 255 : 0};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_val", int'(out_val), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_act_mode", int'(act_mode), 0);
    chk("rst_markers", int'({out_sof, out_sol, out_eol, out_eof}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-pixel frames: exact 2-cycle latency and kernel results.
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, tv[i].win, 4'b1111, tv[i].mode, 1'b1, acc, dlv);
      chk("vec_accept", int'(acc), 1);
      cyc(1'b0, '0, 4'b0000, 2'd0, 1'b1, acc, dlv);
      chk("vec_lat1_val", int'(out_val), 0);
      cyc(1'b0, '0, 4'b0000, 2'd0, 1'b1, acc, dlv);
      chk("vec_lat2_val", int'(out_val), 1);
      chk("vec_data", int'(out_data), tv[i].exp);
    end

    // Mode is latched only on SOF beats.
    cyc(1'b1, win9(1, 2, 3, 4, 5, 6, 7, 8, 9), 4'b1100, 2'd1, 1'b1, acc, dlv);
    cyc(1'b1, win9(9, 8, 7, 6, 5, 4, 3, 2, 1), 4'b0000, 2'd2, 1'b1, acc, dlv);
    chk("latch_mid1", int'(act_mode), 1);
    cyc(1'b1, win9(0, 50, 0, 50, 90, 50, 0, 50, 0), 4'b0011, 2'd2, 1'b1, acc, dlv);
    chk("latch_mid2", int'(act_mode), 1);
    cyc(1'b1, win9(0, 0, 0, 0, 60, 0, 0, 0, 0), 4'b1100, 2'd2, 1'b1, acc, dlv);
    chk("latch_pre_sof", int'(act_mode), 1);
    cyc(1'b0, '0, 4'b0000, 2'd0, 1'b1, acc, dlv);
    chk("latch_new", int'(act_mode), 2);
    idle(3, 1'b1);

    // Reset with two beats stalled in the pipe.
    cyc(1'b1, win9(0, 0, 0, 0, 90, 0, 0, 0, 0), 4'b1100, 2'd3, 1'b0, acc, dlv);
    cyc(1'b1, win9(0, 0, 0, 0, 91, 0, 0, 0, 0), 4'b0000, 2'd3, 1'b0, acc, dlv);
    cyc(1'b0, '0, 4'b0000, 2'd0, 1'b0, acc, dlv);
    chk("full_out_val", int'(out_val), 1);
    chk("full_in_rdy", int'(in3x3_rdy), 0);
    chk("full_act_mode", int'(act_mode), 3);
    @(negedge clk);
    in3x3_val = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_val", int'(out_val), 0);
    chk("mid_rst_act_mode", int'(act_mode), 0);
    q.delete();
    m_mode = 2'd0;
    st_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 4'b0000, 2'd0, 1'b1, acc, dlv);
      chk("post_rst_idle", int'(out_val), 0);
    end
    cyc(1'b1, win9(9, 9, 9, 9, 33, 9, 9, 9, 9), 4'b0000, 2'd1, 1'b1, acc, dlv);
    cyc(1'b0, '0, 4'b0000, 2'd0, 1'b1, acc, dlv);
    cyc(1'b0, '0, 4'b0000, 2'd0, 1'b1, acc, dlv);
    chk("post_rst_first_val", int'(out_val), 1);
    chk("post_rst_first_data", int'(out_data), 33);
    idle(2, 1'b1);

    // Three 10-beat frames under random valid and random backpressure.
    beat = 0; n_out = 0; ncy = 0;
    while (beat < 30 && ncy < 800) begin
      idx = beat % 10;
      v = ($urandom_range(0, 3) != 0);
      rnd = {$urandom, $urandom, $urandom};
      cyc(v, rnd[71:0], {idx == 0, idx % 5 == 0, idx % 5 == 4, idx == 9},
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), acc, dlv);
      if (acc) beat++;
      if (dlv) n_out++;
      ncy++;
    end
    chk("stream_beats_sent", beat, 30);
    ncy = 0;
    while (q.size() != 0 && ncy < 20) begin
      cyc(1'b0, '0, 4'b0000, 2'd0, 1'b1, acc, dlv);
      if (dlv) n_out++;
      ncy++;
    end
    chk("stream_drained", int'(q.size()), 0);
    chk("stream_out_count", n_out, 30);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
